// File: rtl/div_result_reuse_pkg.sv
// Shared types and defaults for the divider result-reuse stage.
package div_result_reuse_pkg;

    localparam int CFG_XLEN = 64;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        VALID
    } divreusestate_t;

endpackage

// File: rtl/div_result_reuse_entry.sv
// Single-entry, value-tagged buffer holding the most recent completed division.
module div_result_reuse_entry
    import div_result_reuse_pkg::*;
#(
    parameter int XLEN     = CFG_XLEN,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            IntDivE,
    input  logic            DivSignedE,
    input  logic            W64E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic            DivStartE,
    input  logic            DivDoneM,
    input  logic            FlushE,
    input  logic [XLEN-1:0] QuotM,
    input  logic [XLEN-1:0] RemM,
    output logic            ReuseHitE,
    output logic [XLEN-1:0] QBuf,
    output logic [XLEN-1:0] RBuf
);

    divreusestate_t  state;
    logic [XLEN-1:0] x_tag;
    logic [XLEN-1:0] d_tag;
    logic            signed_tag;
    logic            w64_tag;
    logic            w64;
    logic            ops_match;
    logic            tag_match;

    // A 32-bit datapath has no W-type ops, so the W flag is forced off there.
    assign w64 = (XLEN > 32) ? W64E : 1'b0;

    always_comb begin
        ops_match = 1'b0;
        if (w64)
            ops_match = (x_tag[31:0] == ForwardedSrcAE[31:0]) &&
                        (d_tag[31:0] == ForwardedSrcBE[31:0]);
        else
            ops_match = (x_tag == ForwardedSrcAE) && (d_tag == ForwardedSrcBE);
        tag_match = ops_match && (signed_tag == DivSignedE) && (w64_tag == w64);
    end

    assign ReuseHitE = REUSE_EN && (state == VALID) && IntDivE && tag_match;

    // A completing divide outranks a same-cycle FlushE: that result already left E.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else if (DivDoneM && (state == FILL)) begin
            state <= VALID;
            QBuf  <= QuotM;
            RBuf  <= RemM;
        end else if (FlushE && (state == FILL)) begin
            state <= EMPTY;
        end else if (DivStartE) begin
            state      <= FILL;
            x_tag      <= ForwardedSrcAE;
            d_tag      <= ForwardedSrcBE;
            signed_tag <= DivSignedE;
            w64_tag    <= w64;
        end
    end

    start_on_hit_a: assert property (@(posedge clk) disable iff (!reset_n)
                                     !(DivStartE && ReuseHitE))
        else $error("DivStartE asserted together with ReuseHitE");

endmodule

// File: rtl/div_result_reuse.sv
// Divider result select, W-type sign extension, reuse-hit tracking and Writeback register.
module div_result_reuse
    import div_result_reuse_pkg::*;
#(
    parameter int XLEN     = CFG_XLEN,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StallM,
    input  logic            FlushE,
    input  logic            FlushM,
    input  logic            StallW,
    input  logic            FlushW,
    input  logic            IntDivE,
    input  logic            DivSignedE,
    input  logic            W64E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic            DivStartE,
    input  logic            DivDoneM,
    input  logic [XLEN-1:0] QuotM,
    input  logic [XLEN-1:0] RemM,
    input  logic            RemSelM,
    input  logic            W64M,
    output logic            ReuseHitE,
    output logic            ReuseHitM,
    output logic [XLEN-1:0] DivResultW,
    output logic            DivResultValidW
);

    logic [XLEN-1:0] q_buf;
    logic [XLEN-1:0] r_buf;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] res;
    logic            valid_next;

    div_result_reuse_entry #(
        .XLEN     (XLEN),
        .REUSE_EN (REUSE_EN)
    ) u_entry (
        .clk            (clk),
        .reset_n        (reset_n),
        .IntDivE        (IntDivE),
        .DivSignedE     (DivSignedE),
        .W64E           (W64E),
        .ForwardedSrcAE (ForwardedSrcAE),
        .ForwardedSrcBE (ForwardedSrcBE),
        .DivStartE      (DivStartE),
        .DivDoneM       (DivDoneM),
        .FlushE         (FlushE),
        .QuotM          (QuotM),
        .RemM           (RemM),
        .ReuseHitE      (ReuseHitE),
        .QBuf           (q_buf),
        .RBuf           (r_buf)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            ReuseHitM <= 1'b0;
        else if (FlushM)
            ReuseHitM <= 1'b0;
        else if (!StallM)
            ReuseHitM <= ReuseHitE & ~FlushE;
    end

    assign src = ReuseHitM ? (RemSelM ? r_buf : q_buf) : (RemSelM ? RemM : QuotM);

    generate
        if (XLEN > 32) begin : g_ext
            assign res = W64M ? {{(XLEN-32){src[31]}}, src[31:0]} : src;
        end else begin : g_noext
            assign res = src;
        end
    endgenerate

    assign valid_next = (DivDoneM | ReuseHitM) & ~FlushM;

    // The result register only loads on a valid result, so a bubble leaves the last value visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            DivResultW      <= '0;
            DivResultValidW <= 1'b0;
        end else if (!StallW) begin
            DivResultValidW <= FlushW ? 1'b0 : valid_next;
            if (valid_next)
                DivResultW <= res;
        end
    end

endmodule

// File: tb/tb_div_result_reuse.sv
// Directed table-driven bench for div_result_reuse with XLEN=64, plus a REUSE_EN=0 twin.
module tb_div_result_reuse;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         stall_m, flush_e, flush_m, stall_w, flush_w;
    logic         int_div, div_signed, w64e, div_start, div_done, rem_sel, w64m;
    logic [W-1:0] src_a, src_b, quot, rem;

    logic         hit_e, hit_m, valid_w;
    logic [W-1:0] res_w;
    logic         hit_e_n, hit_m_n, valid_w_n;
    logic [W-1:0] res_w_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         int_div, sgn, w64e;
        logic [W-1:0] a, b;
        logic         start, fe, done;
        logic [W-1:0] q, r;
        logic         rs, wm;
        logic         exp_hit_e, exp_hit_m, exp_valid;
        logic [W-1:0] exp_res;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    div_result_reuse #(.XLEN(W), .REUSE_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .StallM(stall_m), .FlushE(flush_e), .FlushM(flush_m),
        .StallW(stall_w), .FlushW(flush_w), .IntDivE(int_div), .DivSignedE(div_signed),
        .W64E(w64e), .ForwardedSrcAE(src_a), .ForwardedSrcBE(src_b), .DivStartE(div_start),
        .DivDoneM(div_done), .QuotM(quot), .RemM(rem), .RemSelM(rem_sel), .W64M(w64m),
        .ReuseHitE(hit_e), .ReuseHitM(hit_m), .DivResultW(res_w), .DivResultValidW(valid_w)
    );

    div_result_reuse #(.XLEN(W), .REUSE_EN(1'b0)) dut_noreuse (
        .clk(clk), .reset_n(reset_n), .StallM(stall_m), .FlushE(flush_e), .FlushM(flush_m),
        .StallW(stall_w), .FlushW(flush_w), .IntDivE(int_div), .DivSignedE(div_signed),
        .W64E(w64e), .ForwardedSrcAE(src_a), .ForwardedSrcBE(src_b), .DivStartE(div_start),
        .DivDoneM(div_done), .QuotM(quot), .RemM(rem), .RemSelM(rem_sel), .W64M(w64m),
        .ReuseHitE(hit_e_n), .ReuseHitM(hit_m_n), .DivResultW(res_w_n), .DivResultValidW(valid_w_n)
    );

    function automatic vec_t mk(logic idv, logic s, logic we, logic [W-1:0] a, logic [W-1:0] b,
                                logic st, logic fe, logic dn, logic [W-1:0] q, logic [W-1:0] r,
                                logic rs, logic wm, logic ehe, logic ehm, logic ev,
                                logic [W-1:0] eres);
        vec_t v;
        v.int_div = idv; v.sgn = s; v.w64e = we; v.a = a; v.b = b;
        v.start = st; v.fe = fe; v.done = dn; v.q = q; v.r = r; v.rs = rs; v.wm = wm;
        v.exp_hit_e = ehe; v.exp_hit_m = ehm; v.exp_valid = ev; v.exp_res = eres;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0, '0);
    endfunction

    // Drives one cycle of stimulus; pipeline control defaults to run.
    task automatic applyStimulus(input vec_t v);
        int_div = v.int_div; div_signed = v.sgn; w64e = v.w64e;
        src_a = v.a; src_b = v.b; div_start = v.start; flush_e = v.fe;
        div_done = v.done; quot = v.q; rem = v.r; rem_sel = v.rs; w64m = v.wm;
        stall_m = 1'b0; flush_m = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic runRow(input int idx, input vec_t v);
        applyStimulus(v);
        #2;
        checkOutput("ReuseHitE", idx, {63'd0, hit_e}, {63'd0, v.exp_hit_e});
        checkOutput("ReuseHitE_noreuse", idx, {63'd0, hit_e_n}, '0);
        step();
        checkOutput("ReuseHitM", idx, {63'd0, hit_m}, {63'd0, v.exp_hit_m});
        checkOutput("DivResultValidW", idx, {63'd0, valid_w}, {63'd0, v.exp_valid});
        checkOutput("DivResultW", idx, res_w, v.exp_res);
    endtask

    task automatic checkRegs(input int idx, input logic ehm, input logic ev, input logic [W-1:0] eres);
        checkOutput("ReuseHitM", idx, {63'd0, hit_m}, {63'd0, ehm});
        checkOutput("DivResultValidW", idx, {63'd0, valid_w}, {63'd0, ev});
        checkOutput("DivResultW", idx, res_w, eres);
    endtask

    initial begin
        vec_t v;
        localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
        localparam logic [W-1:0] NEG31 = 64'hFFFF_FFFF_8000_0000;

        // DIV 100/7 then REM 100/7 hits the buffer.
        tbl.push_back(mk(1, 1, 0, 100, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 14, 2, 0, 0, 0, 0, 1, 14));
        tbl.push_back(mk(1, 1, 0, 100, 7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 14));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'hDEAD, 64'hBEEF, 1, 0, 0, 0, 1, 2));
        // DIVW -2^31/-1, then REMW with different upper operand bits.
        tbl.push_back(mk(1, 1, 1, NEG31, 64'h0000_0000_FFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_8000_0000, 0, 0, 1, 0, 0, 1, NEG31));
        tbl.push_back(mk(1, 1, 1, 64'h1234_5678_8000_0000, 64'hABCD_EF00_FFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, NEG31));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'hAAAA, 64'h5555, 1, 1, 0, 0, 1, 0));
        // DIVU 7/0 then signed DIV 7/0 must miss.
        tbl.push_back(mk(1, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ONES, 7, 0, 0, 0, 0, 1, ONES));
        tbl.push_back(mk(1, 1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ONES));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ONES, 7, 1, 0, 0, 0, 1, 7));
        // Flush during FILL empties the entry; a stale done must not fill it.
        tbl.push_back(mk(1, 0, 0, 50, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 1, 10));
        tbl.push_back(mk(1, 0, 0, 50, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
        // DivDoneM together with FlushE still fills the entry.
        tbl.push_back(mk(1, 1, 0, 9, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 1, 0, 9, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4));
        tbl.push_back(mk(1, 1, 0, 9, 2, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 1));
        tbl.push_back(idle());
        tbl[21].exp_res = 1;
        tbl.push_back(mk(1, 1, 0, 64'h1_0000_0009, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        applyStimulus(idle());
        reset_n = 1'b0;
        step();
        step();
        checkRegs(-1, 0, 0, '0);

        for (int i = 0; i < tbl.size(); i++)
            runRow(i, tbl[i]);

        // StallM holds ReuseHitM; FlushM clears it and suppresses the W update.
        v = mk(1, 1, 0, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(v); stall_m = 1'b1; #2;
        checkOutput("ReuseHitE_stall", 100, {63'd0, hit_e}, 64'd1);
        step(); checkRegs(100, 0, 0, 1);
        applyStimulus(v); step(); checkRegs(101, 1, 0, 1);
        applyStimulus(idle()); stall_m = 1'b1; step(); checkRegs(102, 1, 1, 4);
        applyStimulus(idle()); stall_m = 1'b1; flush_m = 1'b1; rem_sel = 1'b1;
        step(); checkRegs(103, 0, 0, 4);

        // StallW holds both outputs; FlushW clears valid.
        v = mk(0, 0, 0, 0, 0, 0, 0, 1, 77, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(v); stall_w = 1'b1; step(); checkRegs(110, 0, 0, 4);
        applyStimulus(v); step(); checkRegs(111, 0, 1, 77);
        applyStimulus(idle()); stall_w = 1'b1; step(); checkRegs(112, 0, 1, 77);
        applyStimulus(idle()); flush_w = 1'b1; step(); checkRegs(113, 0, 0, 77);

        // Reset mid-FILL: a late done must not fill the entry.
        applyStimulus(mk(1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); step();
        applyStimulus(idle()); reset_n = 1'b0; step(); checkRegs(120, 0, 0, 0);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0)); step();
        checkRegs(121, 0, 1, 3);
        applyStimulus(mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); #2;
        checkOutput("ReuseHitE_after_reset_fill", 122, {63'd0, hit_e}, 64'd0);
        step();

        // Reset mid-hit.
        applyStimulus(mk(1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); step();
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0)); step();
        applyStimulus(mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); #2;
        checkOutput("ReuseHitE_prehit", 130, {63'd0, hit_e}, 64'd1);
        checkOutput("ReuseHitE_noreuse", 130, {63'd0, hit_e_n}, 64'd0);
        step(); checkRegs(131, 1, 0, 3);
        applyStimulus(idle()); reset_n = 1'b0; step(); checkRegs(132, 0, 0, 0);
        applyStimulus(mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); #2;
        checkOutput("ReuseHitE_after_reset_hit", 133, {63'd0, hit_e}, 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
